// File: rtl/l7_pc_unit.sv
// Program-counter unit: PC register, branch evaluation, PC-relative target and
// an optional return-address stack, built only when L7_RAS_EN is defined.
module l7_pc_unit #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter int          OFF_W     = 4,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pc_en,
  input  logic                               br_en,
  input  logic [2:0]                         br_type,
  input  logic signed [OFF_W-1:0]            offset,
  input  logic [DATA_W-1:0]                  cond_data,
  output logic [ADDR_W-1:0]                  pc,
  output logic                               taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_empty,
  output logic                               ras_full,
  output logic                               ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] BR_BZ   = 3'd1;
  localparam logic [2:0] BR_BNZ  = 3'd2;
  localparam logic [2:0] BR_JMP  = 3'd3;
  localparam logic [2:0] BR_CALL = 3'd4;
  localparam logic [2:0] BR_RET  = 3'd5;

  // Assigning the signed offset to a wider signed variable sign-extends it;
  // the sum is taken modulo 2^ADDR_W so targets wrap in both directions.
  function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] base,
                                                   input logic signed [OFF_W-1:0] off);
    logic signed [ADDR_W-1:0] off_ext;
    off_ext = off;
    return base + off_ext;
  endfunction

  logic              cond_zero_p0;
  logic [ADDR_W-1:0] target_p0;
  logic [ADDR_W-1:0] pc_nxt_p0;

  assign cond_zero_p0 = (cond_data == '0);
  assign target_p0    = rel_target(pc, offset);

`ifdef L7_RAS_EN
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [CNT_W-1:0]  ras_cnt;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ras_top_p0;
  logic [ADDR_W-1:0] ret_addr_p0;
  logic              call_p0;
  logic              ret_p0;
  logic              push_p0;
  logic              pop_p0;

  assign push_idx    = IDX_W'(ras_cnt);
  assign top_idx     = IDX_W'(ras_cnt - 1'b1);
  assign ras_top_p0  = ras_mem[top_idx];
  assign ret_addr_p0 = pc + 1'b1;
  assign ras_count   = ras_cnt;
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign push_p0     = call_p0 && !ras_full;
  assign pop_p0      = ret_p0 && !ras_empty;
`else
  assign ras_count = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  // Stage p0: branch decode and next-PC selection
  always_comb begin
    taken = 1'b0;
`ifdef L7_RAS_EN
    call_p0 = 1'b0;
    ret_p0  = 1'b0;
`endif
    if (br_en) begin
      case (br_type)
        BR_BZ:  taken = cond_zero_p0;
        BR_BNZ: taken = !cond_zero_p0;
        BR_JMP: taken = 1'b1;
        BR_CALL: begin
          taken = 1'b1;
`ifdef L7_RAS_EN
          call_p0 = 1'b1;
`endif
        end
        BR_RET: begin
`ifdef L7_RAS_EN
          ret_p0 = 1'b1;
          taken  = !ras_empty;
`endif
        end
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_nxt_p0 = pc;
    if (taken)      pc_nxt_p0 = target_p0;
    else if (pc_en) pc_nxt_p0 = pc + 1'b1;
`ifdef L7_RAS_EN
    if (pop_p0)     pc_nxt_p0 = ras_top_p0;
`endif
  end

  // Stage p1: architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= ADDR_W'(RESET_PC);
    else     pc <= pc_nxt_p0;
  end

`ifdef L7_RAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      if (push_p0)     ras_cnt <= ras_cnt + 1'b1;
      else if (pop_p0) ras_cnt <= ras_cnt - 1'b1;
      if ((call_p0 && ras_full) || (ret_p0 && ras_empty)) ras_err <= 1'b1;
    end
  end

  // Stack payload needs no reset: only entries below ras_cnt are ever read.
  always_ff @(posedge clk) begin
    if (push_p0) ras_mem[push_idx] <= ret_addr_p0;
  end
`endif

endmodule

// File: doc/l7_pc_unit.md
# l7_pc_unit

Parametrised program-counter unit for the multicycle core. It replaces the separate PC, branch-condition and branch-target blocks. It holds the PC, evaluates conditional and unconditional branches, computes the PC-relative target and keeps a hardware return-address stack (RAS) for call/return. It sits between the control state machine (which drives `pc_en`, `br_en`, `br_type`) and the memory address mux (which consumes `pc`).

## Interface
Parameters:
- `ADDR_W`, 8: PC / instruction-address width.
- `DATA_W`, 16: width of the register-file operand tested by bz/bnz.
- `OFF_W`, 4: width of the signed branch offset field.
- `RAS_DEPTH`, 4: return-address stack entries (≥1).
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_en`  in  1  sequential increment request.
- `br_en`  in  1  branch-evaluate strobe, one cycle per branch instruction.
- `br_type`  in  3  0 NONE, 1 BZ, 2 BNZ, 3 JMP, 4 CALL, 5 RET, 6–7 reserved (treated as NONE).
- `offset`  in  OFF_W  signed two's-complement branch offset.
- `cond_data`  in  DATA_W  register operand for BZ/BNZ.
- `pc`  out  ADDR_W  current PC, registered.
- `taken`  out  1  combinational: branch taken this cycle.
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid RAS entries.
- `ras_empty`  out  1  `ras_count`==0.
- `ras_full`  out  1  `ras_count`==RAS_DEPTH.
- `ras_err`  out  1  sticky overflow/underflow flag.

## Operation
- Target = `pc` + sign-extend(`offset`) to ADDR_W, modulo 2^ADDR_W (wraps both directions).
- Return address = `pc`+1 modulo 2^ADDR_W.
- `taken` (only when `br_en`=1, else 0):
  - BZ: `cond_data`==0.
  - BNZ: `cond_data`!=0.
  - JMP, CALL: 1.
  - RET: 1 if RAS not empty, else 0.
  - NONE/reserved: 0.
- Next PC priority: RET taken → popped top of RAS; other taken → target; else `pc_en` → `pc`+1; else hold.
- CALL with RAS not full: push return address, `ras_count`+1.
- CALL with RAS full: jump still occurs, push dropped, `ras_count` unchanged, `ras_err`←1.
- RET taken: pop, `ras_count`−1.
- RET on empty: not taken, PC follows the `pc_en` rule, `ras_err`←1.
- RAS is LIFO. Storage is a register array indexed by `ras_count`. Entries beyond `ras_count` are don't-care.
- `ras_err` clears only on reset.
- `pc_en` and `br_en` in the same cycle: a taken branch wins. A not-taken branch lets the increment proceed.

## Timing
- Reset (async assert, released synchronously by the environment): `pc`=RESET_PC, `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0. `taken` is combinational and reads 0 while `br_en`=0.
- `taken` is valid in the same cycle as `br_en`. The SM may use it to pick its next state.
- `pc`, RAS, `ras_count` and flags update on the rising edge that samples `br_en`/`pc_en`. There is one-cycle latency from strobe to new `pc`.
- `ras_empty`/`ras_full` are decoded from registered `ras_count`, so they are glitch-free.
- Reset asserted mid-operation (any cycle, including a CALL edge) immediately forces reset values. No partial push survives.
- Back-to-back CALL/RET on consecutive cycles is legal. RET sees the entry pushed on the previous edge.

## Configuration
- `L7_RAS_EN` defined: RAS, CALL/RET and the `ras_*` outputs behave as described.
- `L7_RAS_EN` undefined:
  - No RAS storage is built.
  - CALL behaves exactly as JMP.
  - RET behaves as NONE (never taken, no error).
  - `ras_count`=0, `ras_empty`=1, `ras_full`=0 and `ras_err`=0 are held constant.

## Test plan
- Reset/increment: `rst`=1 then release, `pc_en`=1 for 5 cycles → `pc` 0,1,2,3,4,5. With `ADDR_W`=8 starting at 8'hFF, one increment → 8'h00.
- BZ/BNZ: `pc`=8'h10, `offset`=4'hD (−3), BZ with `cond_data`=0 → `taken`=1, next `pc`=8'h0D. Same with `cond_data`=16'h0001 and `pc_en`=1 → `taken`=0, next `pc`=8'h11. BNZ is the inverse.
- Wrap: `pc`=8'hFE, JMP `offset`=4'h3 → `pc`=8'h01. `pc`=8'h01, `offset`=4'h8 (−8) → `pc`=8'hF9.
- Call/return nesting (`L7_RAS_EN`): CALL at 8'h20 off +4 → `pc`=8'h24, `ras_count`=1. CALL at 8'h24 off +2 → `pc`=8'h26, `ras_count`=2. RET → 8'h25. RET → 8'h21, `ras_empty`=1, `ras_err`=0.
- Overflow/underflow: 5 CALLs with `RAS_DEPTH`=4 → 5th jumps, `ras_full`=1, `ras_count`=4, `ras_err`=1. Then 5 RETs → 4 pops in LIFO order, 5th not taken, `ras_err` stays 1 until reset.
- Macro off: CALL off +4 at 8'h30 → `pc`=8'h34, `ras_count`=0. RET with `pc_en`=1 → `taken`=0, `pc`=8'h35, `ras_err`=0.
